// File: rtl/pc_seq_pkg.sv
// Shared control-code constants and decode helper for the program-counter sequencer.
// Imported by pc_sequencer.
package pc_seq_pkg;

  localparam int CTL_WIDTH = 11;

  localparam logic [CTL_WIDTH-1:0] CTL_B   = 11'd31;
  localparam logic [CTL_WIDTH-1:0] CTL_BL  = 11'd32;
  localparam logic [CTL_WIDTH-1:0] CTL_RET = 11'd33;

  typedef enum logic [1:0] {
    OP_SEQ,
    OP_B,
    OP_BL,
    OP_RET
  } pc_op_e;

  // Any code other than the three flow-control codes is plain sequential.
  function automatic pc_op_e decode_ctl(input logic [CTL_WIDTH-1:0] code);
    case (code)
      CTL_B:   return OP_B;
      CTL_BL:  return OP_BL;
      CTL_RET: return OP_RET;
      default: return OP_SEQ;
    endcase
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a write pointer plus an occupancy count.
// A push into a full stack overwrites the oldest entry and sets a sticky overflow flag.
module ras_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  // The write pointer always names the next free slot; when full it names the oldest entry.
  assign top      = mem_q[wr_ptr_q - PTR_ONE];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_MAX);
  assign overflow = overflow_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (full) overflow_d = 1'b1;
      else      count_d    = count_q + CNT_ONE;
    end else if (pop && !empty) begin
      wr_ptr_d = wr_ptr_q - PTR_ONE;
      count_d  = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array is not reset; a slot is only read after a push has written it,
  // and the top level substitutes r14_in whenever the stack is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with branch, branch-with-link, return-address stack,
// stall and external redirect. Priority: redirect > stall > control code.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int          PC_WIDTH  = 32,
  parameter int          BR_WIDTH  = 24,
  parameter int unsigned STEP      = 1,
  parameter int unsigned RESET_PC  = 0,
  parameter int          RAS_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [PC_WIDTH-1:0]  redirect_pc,
  input  logic [CTL_WIDTH-1:0] ctl_code,
  input  logic [BR_WIDTH-1:0]  br_offset,
  input  logic [PC_WIDTH-1:0]  r14_in,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [PC_WIDTH-1:0]  pc_next,
  output logic                 link_we,
  output logic [PC_WIDTH-1:0]  link_data,
  output logic                 ras_overflow,
  output logic                 ras_underflow
);

  localparam logic [PC_WIDTH-1:0] STEP_PC  = PC_WIDTH'(STEP);
  localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] seq_pc, br_target, ras_top;
  logic                ras_push, ras_pop, ras_empty;
  pc_op_e              op;

  assign op        = decode_ctl(ctl_code);
  assign seq_pc    = pc_q + STEP_PC;
  assign br_target = pc_q + {{(PC_WIDTH - BR_WIDTH){br_offset[BR_WIDTH-1]}}, br_offset};

  always_comb begin
    pc_d          = seq_pc;
    link_we       = 1'b0;
    ras_push      = 1'b0;
    ras_pop       = 1'b0;
    ras_underflow = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      case (op)
        OP_B:  pc_d = br_target;
        OP_BL: begin
          pc_d     = br_target;
          link_we  = rst_n;
          ras_push = rst_n;
        end
        OP_RET: begin
          ras_pop = rst_n;
          if (ras_empty) begin
            pc_d          = r14_in;
            ras_underflow = rst_n;
          end else begin
            pc_d = ras_top;
          end
        end
        default: pc_d = seq_pc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC_V;
    else        pc_q <= pc_d;
  end

  assign pc        = pc_q;
  assign pc_next   = pc_d;
  assign link_data = seq_pc;

  ras_stack #(
    .WIDTH(PC_WIDTH),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (ras_push),
    .pop     (ras_pop),
    .din     (seq_pc),
    .top     (ras_top),
    .empty   (ras_empty),
    .full    (),
    .overflow(ras_overflow)
  );

endmodule
